mips_multicycle_control: RTL

- Multicycle MIPS control unit: a Moore FSM that decodes the latched instruction's opcode/funct and sequences the datapath control strobes.
- Sits on the control side of the shared-memory multicycle datapath. The datapath gains IR/A/B/ALUOut registers; the control unit drives every select and write-enable.
- Supported instructions: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.
- Also provides a retired-instruction counter and a sticky illegal-instruction flag.

---
 rtl/mips_multicycle_control.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing the multicycle MIPS datapath strobes
module mips_multicycle_control #(
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          Op,
    input  logic [5:0]          Funct,
    input  logic                Zero,
    output logic                IorD,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUControl,
    output logic [1:0]          PCSrc,
    output logic                Branch,
    output logic                PCEn,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [CNT_BITS-1:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       branch;
        logic       pc_write;
    } ctrl_t;

    state_t cur, nxt;
    ctrl_t  ctrl;
    logic   funct_ok, bad, retire;

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        return f == 6'b100000 ? 3'b010 :
               f == 6'b100010 ? 3'b110 :
               f == 6'b100100 ? 3'b000 :
               f == 6'b100101 ? 3'b001 :
               f == 6'b101010 ? 3'b111 : 3'b010;
    endfunction

    // Strobes are computed for the state being entered so they register alongside it
    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        c.alu_control = 3'b010;
        case (s)
            FETCH:    begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR,
            ADDIEX:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMREAD:  c.iord = 1'b1;
            MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
            EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_control = alu_of(f); end
            ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            BRANCH:   begin c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01; c.branch = 1'b1; end
            ADDIWB:   c.reg_write = 1'b1;
            JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default:  c = ctrl;
        endcase
        return c;
    endfunction

    assign funct_ok = Funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Next-state decode; unused encodings fall back to FETCH
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = (Op == 6'b100011 || Op == 6'b101011) ? MEMADR :
                           Op == 6'b000000 ? EXECUTE :
                           Op == 6'b000100 ? BRANCH :
                           Op == 6'b001000 ? ADDIEX :
                           Op == 6'b000010 ? JUMP : FETCH;
            MEMADR:  nxt = Op == 6'b100011 ? MEMREAD : MEMWRITE;
            MEMREAD: nxt = MEMWB;
            EXECUTE: nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    assign bad    = (cur == DECODE && nxt == FETCH) || (cur == EXECUTE && !funct_ok);
    assign retire = cur inside {MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP};

    // State, registered strobes, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= FETCH;
            ctrl        <= ctrl_of(FETCH, Funct);
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            cur         <= nxt;
            ctrl        <= ctrl_of(nxt, Funct);
            illegal     <= illegal | bad;
            instr_count <= instr_count + {{(CNT_BITS-1){1'b0}}, retire};
        end
    end

    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUControl = ctrl.alu_control;
    assign PCSrc      = ctrl.pc_src;
    assign Branch     = ctrl.branch;
    assign PCEn       = ctrl.pc_write | (ctrl.branch & Zero);
    assign state      = cur;
endmodule
